// File: rtl/wave_length_divider_if.sv
// Request/result bundle between the frequency source, the divider and the
// waveform generators.
`timescale 1ns/1ps
interface wave_length_divider_if;
    logic [31:0] frequency_in;
    logic        frequency_valid;
    logic        frequency_ready;
    logic [31:0] wave_length;
    logic        wave_length_valid;
    logic        busy;

    modport master (
        output frequency_in,
        output frequency_valid,
        input  frequency_ready,
        input  wave_length,
        input  wave_length_valid,
        input  busy
    );

    modport slave (
        input  frequency_in,
        input  frequency_valid,
        output frequency_ready,
        output wave_length,
        output wave_length_valid,
        output busy
    );
endinterface

// File: rtl/wave_length_divider.sv
// Sequential restoring divider: wave_length = (CLOCK_FREQUENCY << FRAC_BITS)
// / frequency_in, one quotient bit per cycle, saturating to 32 bits.
`timescale 1ns/1ps
module wave_length_divider #(
    parameter int unsigned CLOCK_FREQUENCY = 24000000,
    parameter int unsigned FRAC_BITS       = 20,
    parameter int unsigned DIV_WIDTH       = 32 + FRAC_BITS
) (
    input logic                  clk,
    input logic                  reset_n,
    wave_length_divider_if.slave wl
);
    localparam int unsigned CNT_W = $clog2(DIV_WIDTH + 1);

    localparam logic [63:0] DIVIDEND_64 =
        64'(CLOCK_FREQUENCY) << FRAC_BITS;
    localparam logic [DIV_WIDTH-1:0] DIVIDEND =
        DIVIDEND_64[DIV_WIDTH-1:0];

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DIVIDE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]           r_state;
    logic [31:0]          r_divisor;
    logic [31:0]          r_rem;
    logic [DIV_WIDTH-1:0] r_work;
    logic [CNT_W-1:0]     r_count;
    logic [31:0]          r_wave_length;
    logic                 r_wave_valid;

    logic [32:0]          w_rem_shift;
    logic [32:0]          w_rem_sub;
    logic                 w_qbit;
    logic                 w_sat;

    // r_work holds the dividend; quotient bits fill the vacated LSBs.
    assign w_rem_shift = {r_rem, r_work[DIV_WIDTH-1]};
    assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
    assign w_qbit      = ~w_rem_sub[32];
    assign w_sat       = |r_work[DIV_WIDTH-1:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_work        <= '0;
            r_count       <= '0;
            r_wave_length <= '0;
            r_wave_valid  <= 1'b0;
        end else begin
            r_wave_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (wl.frequency_valid) begin
                        r_divisor <= wl.frequency_in;
                        r_rem     <= '0;
                        r_count   <= CNT_W'(DIV_WIDTH);
                        if (wl.frequency_in == '0) begin
                            r_work  <= '1;
                            r_state <= S_DONE;
                        end else begin
                            r_work  <= DIVIDEND;
                            r_state <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    r_rem   <= w_qbit ? w_rem_sub[31:0]
                                      : w_rem_shift[31:0];
                    r_work  <= {r_work[DIV_WIDTH-2:0], w_qbit};
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_wave_length <= w_sat ? '1 : r_work[31:0];
                    r_wave_valid  <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wl.frequency_ready   = (r_state == S_IDLE);
    assign wl.busy              = (r_state != S_IDLE);
    assign wl.wave_length       = r_wave_length;
    assign wl.wave_length_valid = r_wave_valid;
endmodule

// File: tb/tb_wave_length_divider.sv
// Directed bench for wave_length_divider: latency, saturation, handshake,
// mid-conversion reset and a 55..1000 Hz sweep against a reference divide.
`timescale 1ns/1ps
module tb_wave_length_divider;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    wave_length_divider_if bus();

    wave_length_divider dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wl      (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] f);
        logic [63:0] q;
        if (f == 32'd0) return 32'hFFFF_FFFF;
        q = (64'd24000000 << 20) / {32'd0, f};
        return (q > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : q[31:0];
    endfunction

    // Accept one request, then scramble frequency_in so only the accept
    // edge can matter; lat counts edges from accept to the valid pulse.
    task automatic convert(input  logic [31:0] f,
                           output int          lat,
                           output logic [31:0] res);
        logic [31:0] prev;
        int          bad;
        bit          done;
        @(negedge clk);
        check("ready_pre", bus.frequency_ready, 1);
        bus.frequency_in    = f;
        bus.frequency_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.frequency_valid = 1'b0;
        bus.frequency_in    = $urandom;
        prev = bus.wave_length;
        lat  = 0;
        bad  = 0;
        done = 1'b0;
        res  = '0;
        while (!done && lat < 200) begin
            if (bus.frequency_ready !== 1'b0 || bus.busy !== 1'b1 ||
                bus.wave_length !== prev)
                bad++;
            @(posedge clk);
            #1;
            lat++;
            if (bus.wave_length_valid === 1'b1) done = 1'b1;
        end
        check("done", done, 1);
        check("busy_hold", bad, 0);
        res = bus.wave_length;
        check("ready_with_valid", bus.frequency_ready, 1);
        @(posedge clk);
        #1;
        check("pulse_width", bus.wave_length_valid, 0);
    endtask

    logic [31:0] v_freq [10];
    logic [31:0] v_exp  [10];
    int          v_lat  [10];

    initial begin
        int          lat;
        logic [31:0] res;
        logic [31:0] fq;
        int          acc;
        int          pulses;
        int          p_at  [2];
        logic [31:0] p_val [2];

        // 48 MHz << 20 does not fit in Q12.20; it wraps to 0xC0000000.
        v_freq = '{32'd57671680, 32'd1048576000, 32'd461373440,
                   32'd461897728, 32'd0, 32'd1, 32'hC000_0000,
                   32'hFFFF_FFFF, 32'd5859, 32'd5860};
        v_exp  = '{32'd436363, 32'd24000, 32'd54545, 32'd54483,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7812,
                   32'd5859, 32'hFFFF_FFFF, 32'd4294509215};
        v_lat  = '{53, 53, 53, 53, 1, 53, 53, 53, 53, 53};

        bus.frequency_in    = '0;
        bus.frequency_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wave_length", bus.wave_length, 0);
        check("rst_valid", bus.wave_length_valid, 0);
        check("rst_ready", bus.frequency_ready, 1);
        check("rst_busy", bus.busy, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            convert(v_freq[i], lat, res);
            check($sformatf("lat_%0d", i), lat, v_lat[i]);
            check($sformatf("result_%0d", i), res, v_exp[i]);
            repeat (5) @(negedge clk);
            check($sformatf("hold_%0d", i), bus.wave_length, v_exp[i]);
        end

        // Valid held high across a conversion with a changing input.
        @(negedge clk);
        bus.frequency_in    = 32'd1048576000;
        bus.frequency_valid = 1'b1;
        acc    = 0;
        pulses = 0;
        p_at   = '{-1, -1};
        p_val  = '{32'd0, 32'd0};
        for (int i = 0; i < 108; i++) begin
            if (bus.frequency_valid && bus.frequency_ready) acc++;
            @(posedge clk);
            #1;
            if (i == 0) bus.frequency_in = 32'd57671680;
            if (bus.wave_length_valid) begin
                if (pulses < 2) begin
                    p_at[pulses]  = i;
                    p_val[pulses] = bus.wave_length;
                end
                pulses++;
            end
            @(negedge clk);
        end
        bus.frequency_valid = 1'b0;
        check("b2b_accepts", acc, 2);
        check("b2b_pulses", pulses, 2);
        check("b2b_first", p_val[0], 24000);
        check("b2b_first_at", p_at[0], 53);
        check("b2b_second", p_val[1], 436363);
        check("b2b_second_at", p_at[1], 107);

        // Reset asserted 20 cycles into a conversion.
        @(negedge clk);
        bus.frequency_in    = 32'd57671680;
        bus.frequency_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.frequency_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wave_length", bus.wave_length, 0);
        check("mid_rst_valid", bus.wave_length_valid, 0);
        check("mid_rst_ready", bus.frequency_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.wave_length_valid) pulses++;
        end
        check("mid_rst_no_pulse", pulses, 0);
        check("mid_rst_wl_kept", bus.wave_length, 0);
        convert(32'd1048576000, lat, res);
        check("post_rst_lat", lat, 53);
        check("post_rst_result", res, 24000);

        // 1% steps from 55 Hz up to 1000 Hz.
        fq = 32'd57671680;
        while (fq <= 32'd1048576000) begin
            convert(fq, lat, res);
            check($sformatf("sweep_%0d", fq), res, model(fq));
            fq = fq + fq / 100;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
